// File: rtl/psi_pow4_gen.sv
// psi^4 generator: two paired input FIFOs, a chained double-precision multiply,
// and an alpha_rr delay line aligned SUB_LAT cycles behind psi_pow4.

// Input FIFO with registered ready, so there is no combinational path from wr_vld.
module psi_pow4_gen_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] wr_data,
  input  logic         wr_vld,
  output logic         wr_rdy,
  output logic [W-1:0] rd_data,
  input  logic         rd_en,
  output logic         not_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_nxt;
  logic          wr;

  assign wr        = wr_vld & wr_rdy;
  assign count_nxt = count + (AW+1)'(wr) - (AW+1)'(rd_en);
  assign rd_data   = mem[rd_ptr];
  assign not_empty = (count != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      wr_rdy <= 1'b0;
    end else begin
      if (wr)    wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      count  <= count_nxt;
      wr_rdy <= (count_nxt != FULL_CNT);
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= wr_data;
  end
endmodule

// Behavioural stand-in for the double multiply core: fixed latency, no reset,
// subnormal operands and underflowed results flush to signed zero, RNE rounding.
module floating_point_0 #(
  parameter int LAT = 6
) (
  input  logic        aclk,
  input  logic        s_axis_a_tvalid,
  input  logic [63:0] s_axis_a_tdata,
  input  logic        s_axis_b_tvalid,
  input  logic [63:0] s_axis_b_tdata,
  input  logic        m_axis_result_tready,
  output logic        m_axis_result_tvalid,
  output logic [63:0] m_axis_result_tdata
);
  function automatic logic [63:0] fp_mul(input logic [63:0] a, input logic [63:0] b);
    logic         sign, guard, sticky;
    logic [10:0]  ea, eb;
    logic [51:0]  fa, fb, frac;
    logic [105:0] prod;
    logic [52:0]  rnd;
    int           e;
    sign = a[63] ^ b[63];
    ea = a[62:52]; fa = a[51:0];
    eb = b[62:52]; fb = b[51:0];
    if ((ea == 11'h7FF && fa != '0) || (eb == 11'h7FF && fb != '0) ||
        (ea == 11'h7FF && eb == '0) || (eb == 11'h7FF && ea == '0))
      return 64'h7FF8_0000_0000_0000;
    if (ea == 11'h7FF || eb == 11'h7FF) return {sign, 11'h7FF, 52'd0};
    if (ea == '0 || eb == '0)           return {sign, 63'd0};
    prod = 106'({1'b1, fa}) * 106'({1'b1, fb});
    e = int'(ea) + int'(eb) - 1023;
    if (prod[105]) begin
      frac = prod[104:53]; guard = prod[52]; sticky = |prod[51:0];
      e = e + 1;
    end else begin
      frac = prod[103:52]; guard = prod[51]; sticky = |prod[50:0];
    end
    rnd = {1'b0, frac} + 53'(guard & (sticky | frac[0]));
    if (rnd[52]) e = e + 1;
    frac = rnd[51:0];
    if (e >= 2047) return {sign, 11'h7FF, 52'd0};
    if (e <= 0)    return {sign, 63'd0};
    return {sign, 11'(e), frac};
  endfunction

  logic [63:0] res_pipe [LAT];
  logic [LAT-1:0] vld_pipe;

  always_ff @(posedge aclk) begin
    if (m_axis_result_tready) begin
      res_pipe[0] <= fp_mul(s_axis_a_tdata, s_axis_b_tdata);
      vld_pipe    <= {vld_pipe[LAT-2:0], s_axis_a_tvalid & s_axis_b_tvalid};
      for (int i = 1; i < LAT; i++) res_pipe[i] <= res_pipe[i-1];
    end
  end

  assign m_axis_result_tdata  = res_pipe[LAT-1];
  assign m_axis_result_tvalid = vld_pipe[LAT-1];
endmodule

module psi_pow4_gen #(
  parameter int DEPTH   = 16,
  parameter int MUL_LAT = 6,
  parameter int SUB_LAT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] psi,
  input  logic        psi_vld,
  output logic        psi_rdy,
  input  logic [63:0] alpha_in,
  input  logic        alpha_in_vld,
  output logic        alpha_in_rdy,
  output logic [63:0] psi_pow4,
  output logic        psipow4_vld,
  output logic [63:0] alpha_rr,
  output logic        alpha_rr_vld,
  output logic [31:0] pair_cnt
);
  localparam int VLD_LEN   = 2*MUL_LAT;
  localparam int ALPHA_LEN = 2*MUL_LAT + SUB_LAT;

  logic [63:0] psi_head, alpha_head, mul_a_res, mul_b_res, pow4_hold;
  logic        psi_ne, alpha_ne, issue;
  logic        mul_a_tvalid_unused, mul_b_tvalid_unused;
  logic [VLD_LEN-1:0]   vld_sr;
  logic [ALPHA_LEN-2:0] dl_vld;
  logic [63:0]          dl_data [ALPHA_LEN-1];

  psi_pow4_gen_fifo #(.DEPTH(DEPTH), .W(64)) u_psi_fifo (
    .clk(clk), .rst_n(rst_n), .wr_data(psi), .wr_vld(psi_vld), .wr_rdy(psi_rdy),
    .rd_data(psi_head), .rd_en(issue), .not_empty(psi_ne)
  );

  psi_pow4_gen_fifo #(.DEPTH(DEPTH), .W(64)) u_alpha_fifo (
    .clk(clk), .rst_n(rst_n), .wr_data(alpha_in), .wr_vld(alpha_in_vld), .wr_rdy(alpha_in_rdy),
    .rd_data(alpha_head), .rd_en(issue), .not_empty(alpha_ne)
  );

  assign issue = psi_ne & alpha_ne;

  floating_point_0 #(.LAT(MUL_LAT)) u_mul_a (
    .aclk(clk),
    .s_axis_a_tvalid(issue), .s_axis_a_tdata(psi_head),
    .s_axis_b_tvalid(issue), .s_axis_b_tdata(psi_head),
    .m_axis_result_tready(1'b1),
    .m_axis_result_tvalid(mul_a_tvalid_unused), .m_axis_result_tdata(mul_a_res)
  );

  floating_point_0 #(.LAT(MUL_LAT)) u_mul_b (
    .aclk(clk),
    .s_axis_a_tvalid(vld_sr[MUL_LAT-1]), .s_axis_a_tdata(mul_a_res),
    .s_axis_b_tvalid(vld_sr[MUL_LAT-1]), .s_axis_b_tdata(mul_a_res),
    .m_axis_result_tready(1'b1),
    .m_axis_result_tvalid(mul_b_tvalid_unused), .m_axis_result_tdata(mul_b_res)
  );

  // Core tvalids are not reset, so validity is tracked here instead.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_sr       <= '0;
      dl_vld       <= '0;
      pow4_hold    <= '0;
      alpha_rr     <= '0;
      alpha_rr_vld <= 1'b0;
      pair_cnt     <= '0;
    end else begin
      vld_sr       <= {vld_sr[VLD_LEN-2:0], issue};
      dl_vld       <= {dl_vld[ALPHA_LEN-3:0], issue};
      alpha_rr_vld <= dl_vld[ALPHA_LEN-2];
      if (dl_vld[ALPHA_LEN-2]) alpha_rr <= dl_data[ALPHA_LEN-2];
      if (psipow4_vld) pow4_hold <= mul_b_res;
      if (issue) pair_cnt <= pair_cnt + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    dl_data[0] <= alpha_head;
    for (int i = 1; i < ALPHA_LEN-1; i++) dl_data[i] <= dl_data[i-1];
  end

  assign psipow4_vld = vld_sr[VLD_LEN-1];
  assign psi_pow4    = psipow4_vld ? mul_b_res : pow4_hold;
endmodule

// File: tb/tb_psi_pow4_gen.sv
// Bench for psi_pow4_gen: queue-based reference model checked every cycle,
// plus directed literal expectations on the test-plan scenarios.
module tb_psi_pow4_gen;
  localparam int DEPTH = 16, MUL_LAT = 6, SUB_LAT = 8;
  localparam int P_LAT = 2*MUL_LAT, A_LAT = 2*MUL_LAT + SUB_LAT;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic [63:0] psi = '0, alpha_in = '0;
  logic        psi_vld = 1'b0, alpha_in_vld = 1'b0;
  logic        psi_rdy, alpha_in_rdy, psipow4_vld, alpha_rr_vld;
  logic [63:0] psi_pow4, alpha_rr;
  logic [31:0] pair_cnt;

  always #5 clk = ~clk;

  psi_pow4_gen #(.DEPTH(DEPTH), .MUL_LAT(MUL_LAT), .SUB_LAT(SUB_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .psi(psi), .psi_vld(psi_vld), .psi_rdy(psi_rdy),
    .alpha_in(alpha_in), .alpha_in_vld(alpha_in_vld), .alpha_in_rdy(alpha_in_rdy),
    .psi_pow4(psi_pow4), .psipow4_vld(psipow4_vld),
    .alpha_rr(alpha_rr), .alpha_rr_vld(alpha_rr_vld), .pair_cnt(pair_cnt)
  );

  int checks = 0, errors = 0;

  typedef struct { int t; logic [63:0] v; } exp_t;
  exp_t        exp_p[$], exp_a[$];
  logic [63:0] mq_psi[$], mq_alpha[$];
  int          mcyc = 0;
  logic [31:0] m_cnt = '0;
  logic [63:0] last_p = '0, last_a = '0, mp, ma;
  logic        chk_en = 1'b0, prev_rst = 1'b0, pv, av, rdy_p, rdy_a;

  function automatic logic [63:0] pow4_ref(input logic [63:0] x);
    real r;
    r = $bitstoreal(x);
    r = r * r;
    r = r * r;
    return $realtobits(r);
  endfunction

  task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, mcyc);
    end
  endtask

  // Reference model: pair whenever both queues hold data, results due at fixed offsets.
  always @(negedge clk) begin
    if (chk_en) begin
      rdy_p = prev_rst && (mq_psi.size() < DEPTH);
      rdy_a = prev_rst && (mq_alpha.size() < DEPTH);
      chk64("pair_cnt", pair_cnt, m_cnt);
      chk64("psi_rdy", psi_rdy, rdy_p);
      chk64("alpha_in_rdy", alpha_in_rdy, rdy_a);
      pv = (exp_p.size() > 0) && (exp_p[0].t == mcyc);
      av = (exp_a.size() > 0) && (exp_a[0].t == mcyc);
      chk64("psipow4_vld", psipow4_vld, pv);
      chk64("alpha_rr_vld", alpha_rr_vld, av);
      if (pv) begin last_p = exp_p[0].v; void'(exp_p.pop_front()); end
      if (av) begin last_a = exp_a[0].v; void'(exp_a.pop_front()); end
      chk64("psi_pow4", psi_pow4, last_p);
      chk64("alpha_rr", alpha_rr, last_a);
      if (mq_psi.size() > 0 && mq_alpha.size() > 0) begin
        mp = mq_psi.pop_front();
        ma = mq_alpha.pop_front();
        exp_p.push_back('{t: mcyc + P_LAT, v: pow4_ref(mp)});
        exp_a.push_back('{t: mcyc + A_LAT, v: ma});
        m_cnt = m_cnt + 32'd1;
      end
      if (psi_vld && rdy_p)      mq_psi.push_back(psi);
      if (alpha_in_vld && rdy_a) mq_alpha.push_back(alpha_in);
    end
    if (!rst_n) begin
      mq_psi.delete(); mq_alpha.delete(); exp_p.delete(); exp_a.delete();
      m_cnt = '0; last_p = '0; last_a = '0; chk_en = 1'b1;
    end
    prev_rst = rst_n;
    mcyc++;
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic idle();
    psi_vld = 1'b0; alpha_in_vld = 1'b0;
  endtask

  function automatic logic [63:0] rand_psi();
    logic [63:0] r;
    r = {$urandom, $urandom};
    r[62:52] = 11'(923 + $urandom_range(0, 200));
    return r;
  endfunction

  initial begin
    tick(3);
    rst_n = 1'b1;
    tick(3);

    // single pair: handshake in cycle 0
    psi = 64'h4000_0000_0000_0000; alpha_in = 64'h4008_0000_0000_0000;
    psi_vld = 1'b1; alpha_in_vld = 1'b1;
    tick(); idle();
    tick(12);
    @(negedge clk);
    chk64("single_vld13", psipow4_vld, 1'b1);
    chk64("single_pow4", psi_pow4, 64'h4030_0000_0000_0000);
    chk64("single_cnt", pair_cnt, 32'd1);
    tick(8);
    @(negedge clk);
    chk64("single_avld21", alpha_rr_vld, 1'b1);
    chk64("single_alpha", alpha_rr, 64'h4008_0000_0000_0000);
    tick(5);

    // stream of 100 random pairs at full rate
    for (int i = 0; i < 100; i++) begin
      psi = rand_psi(); alpha_in = {$urandom, $urandom};
      psi_vld = 1'b1; alpha_in_vld = 1'b1;
      tick();
    end
    idle();
    tick(30);

    // skewed: psi first, alphas 20 cycles later
    for (int i = 0; i < 5; i++) begin
      psi = rand_psi(); psi_vld = 1'b1; tick();
    end
    idle();
    tick(20);
    for (int i = 0; i < 5; i++) begin
      alpha_in = {$urandom, $urandom}; alpha_in_vld = 1'b1; tick();
    end
    idle();
    tick(30);

    // full psi FIFO
    for (int i = 0; i < DEPTH; i++) begin
      psi = $realtobits(real'(i + 1)); psi_vld = 1'b1; tick();
    end
    psi = 64'h4059_0000_0000_0000;
    @(negedge clk);
    chk64("full_rdy", psi_rdy, 1'b0);
    tick(2); idle();
    alpha_in = 64'h3FF0_0000_0000_0000; alpha_in_vld = 1'b1;
    tick(); idle();
    @(negedge clk);
    chk64("full_rdy_issue", psi_rdy, 1'b0);
    tick();
    @(negedge clk);
    chk64("full_rdy_back", psi_rdy, 1'b1);
    for (int i = 0; i < DEPTH-1; i++) begin
      alpha_in = 64'(i + 100); alpha_in_vld = 1'b1; tick();
    end
    idle();
    tick(30);

    // reset mid-flight: 4 pairs, reset pulse in cycle 5
    for (int i = 0; i < 4; i++) begin
      psi = rand_psi(); alpha_in = {$urandom, $urandom};
      psi_vld = 1'b1; alpha_in_vld = 1'b1; tick();
    end
    idle();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk64("rst_cnt", pair_cnt, 32'd0);
    chk64("rst_rdy", psi_rdy, 1'b0);
    tick(25);
    psi = 64'hC000_0000_0000_0000; alpha_in = 64'h4014_0000_0000_0000;
    psi_vld = 1'b1; alpha_in_vld = 1'b1;
    tick(); idle();
    tick(12);
    @(negedge clk);
    chk64("post_rst_vld", psipow4_vld, 1'b1);
    chk64("post_rst_pow4", psi_pow4, 64'h4030_0000_0000_0000);
    chk64("post_rst_cnt", pair_cnt, 32'd1);
    tick(20);

    // special values
    psi = 64'hBFF8_0000_0000_0000; alpha_in = 64'h7FF8_0000_0000_0001;
    psi_vld = 1'b1; alpha_in_vld = 1'b1; tick();
    psi = 64'h0000_0000_0000_0000; alpha_in = 64'h8000_0000_0000_0000; tick();
    psi = 64'h7FF0_0000_0000_0000; alpha_in = 64'h0000_0000_0000_0001; tick();
    idle();
    tick(10);
    @(negedge clk);
    chk64("spec_m1p5", psi_pow4, 64'h4014_4000_0000_0000);
    tick();
    @(negedge clk);
    chk64("spec_zero", psi_pow4, 64'h0000_0000_0000_0000);
    tick();
    @(negedge clk);
    chk64("spec_inf", psi_pow4, 64'h7FF0_0000_0000_0000);
    tick(6);
    @(negedge clk);
    chk64("spec_alpha_nan", alpha_rr, 64'h7FF8_0000_0000_0001);
    tick(2);
    @(negedge clk);
    chk64("spec_alpha_denorm", alpha_rr, 64'h0000_0000_0000_0001);
    tick(10);

    @(negedge clk);
    chk64("pending_psi", 64'(exp_p.size()), 64'd0);
    chk64("pending_alpha", 64'(exp_a.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
